// File: rtl/lane_lamp_driver.sv
// Lamp driver behind the traffic-light FSM: decodes light_signal into per-lane
// red/yellow/green lamps. It enforces the minimum yellow time and the all-red
// clearance, and latches a flashing-red fault on illegal codes.
// Ports: clk, rst_n (async, active-low), light_signal[3:0], flash_clr ->
//        lamp_red/lamp_yellow/lamp_green[3:0] (bit0 NS1 .. bit3 EW2), clearing, fault.
module lane_lamp_driver #(
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned MIN_YELLOW   = 3,
  parameter int unsigned FLASH_HALF   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] light_signal,
  input  logic       flash_clr,
  output logic [3:0] lamp_red,
  output logic [3:0] lamp_yellow,
  output logic [3:0] lamp_green,
  output logic       clearing,
  output logic       fault
);

  localparam logic [7:0] CLR_LOAD   = 8'(CLEAR_CYCLES - 1);
  localparam logic [7:0] YEL_LOAD   = 8'(MIN_YELLOW - 1);
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_HALF - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_ALL_RED,
    S_GREEN,
    S_YELLOW,
    S_FAULT
  } state_t;

  state_t     st, st_nxt;
  logic [1:0] lane, lane_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] fcnt, fcnt_nxt;
  logic [3:0] red_nxt, yellow_nxt, green_nxt;
  logic       flash_toggle;

  logic       illegal, is_green, is_yellow;
  logic [1:0] code_lane;

  // Green codes are odd (1,3,5,7), yellow codes even (2,4,6,8); (code-1)>>1 maps both to the lane.
  assign illegal   = light_signal > 4'd8;
  assign is_green  = !illegal && light_signal[0];
  assign is_yellow = !illegal && (light_signal != 4'd0) && !light_signal[0];
  assign code_lane = 2'((light_signal - 4'd1) >> 1);

  always_comb begin
    st_nxt       = st;
    lane_nxt     = lane;
    cnt_nxt      = cnt;
    fcnt_nxt     = fcnt;
    flash_toggle = 1'b0;

    if (st != S_FAULT && illegal) begin
      st_nxt   = S_FAULT;
      fcnt_nxt = FLASH_LOAD;
    end else begin
      case (st)
        S_CLEAR: begin
          if (cnt != 8'd0) begin
            cnt_nxt = cnt - 8'd1;
          end else if (is_green) begin
            st_nxt   = S_GREEN;
            lane_nxt = code_lane;
          end else begin
            st_nxt = S_ALL_RED;
          end
        end
        S_ALL_RED: begin
          if (is_green) begin
            st_nxt   = S_GREEN;
            lane_nxt = code_lane;
          end
        end
        S_GREEN: begin
          if (!(is_green && code_lane == lane)) begin
            st_nxt  = S_YELLOW;
            cnt_nxt = YEL_LOAD;
          end
        end
        S_YELLOW: begin
          if (cnt != 8'd0) begin
            cnt_nxt = cnt - 8'd1;
          end else if (!(is_yellow && code_lane == lane)) begin
            st_nxt  = S_CLEAR;
            cnt_nxt = CLR_LOAD;
          end
        end
        S_FAULT: begin
          if (flash_clr && light_signal == 4'd0) begin
            st_nxt  = S_CLEAR;
            cnt_nxt = CLR_LOAD;
          end else if (fcnt != 8'd0) begin
            fcnt_nxt = fcnt - 8'd1;
          end else begin
            fcnt_nxt     = FLASH_LOAD;
            flash_toggle = 1'b1;
          end
        end
        default: begin
          st_nxt  = S_CLEAR;
          cnt_nxt = CLR_LOAD;
        end
      endcase
    end

    // Lamps are decoded from the next state so they register on the same edge as st.
    green_nxt  = '0;
    yellow_nxt = '0;
    if (st_nxt == S_GREEN)  green_nxt  = 4'b0001 << lane_nxt;
    if (st_nxt == S_YELLOW) yellow_nxt = 4'b0001 << lane_nxt;

    if (st_nxt == S_FAULT) begin
      if (st != S_FAULT)      red_nxt = '1;
      else if (flash_toggle)  red_nxt = ~lamp_red;
      else                    red_nxt = lamp_red;
    end else begin
      red_nxt = ~(green_nxt | yellow_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_CLEAR;
      lane        <= '0;
      cnt         <= CLR_LOAD;
      fcnt        <= '0;
      lamp_red    <= '1;
      lamp_yellow <= '0;
      lamp_green  <= '0;
      clearing    <= 1'b1;
      fault       <= 1'b0;
    end else begin
      st          <= st_nxt;
      lane        <= lane_nxt;
      cnt         <= cnt_nxt;
      fcnt        <= fcnt_nxt;
      lamp_red    <= red_nxt;
      lamp_yellow <= yellow_nxt;
      lamp_green  <= green_nxt;
      clearing    <= (st_nxt == S_CLEAR);
      fault       <= (st_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_lane_lamp_driver.sv
module tb_lane_lamp_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] light_signal = 4'd0;
  logic       flash_clr = 1'b0;
  logic [3:0] lamp_red, lamp_yellow, lamp_green;
  logic       clearing, fault;

  lane_lamp_driver #(
    .CLEAR_CYCLES(4),
    .MIN_YELLOW  (3),
    .FLASH_HALF  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .light_signal(light_signal),
    .flash_clr   (flash_clr),
    .lamp_red    (lamp_red),
    .lamp_yellow (lamp_yellow),
    .lamp_green  (lamp_green),
    .clearing    (clearing),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Packed as {red, yellow, green, clearing, fault}
  logic [13:0] dut_out;
  assign dut_out = {lamp_red, lamp_yellow, lamp_green, clearing, fault};

  typedef struct {
    string       name;
    logic [3:0]  code;
    logic        clr;
    int unsigned n;
    logic [13:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [13:0] sb_exp[$];
  string       sb_name[$];
  int unsigned checks = 0;
  int unsigned fails  = 0;

  function automatic logic [13:0] o(logic [3:0] r, logic [3:0] y, logic [3:0] g,
                                    logic c, logic f);
    return {r, y, g, c, f};
  endfunction

  function automatic logic [13:0] grn(logic [3:0] g);
    return o(~g, 4'h0, g, 1'b0, 1'b0);
  endfunction

  function automatic logic [13:0] yel(logic [3:0] y);
    return o(~y, y, 4'h0, 1'b0, 1'b0);
  endfunction

  logic [13:0] CLR, ARED, FLT_ON, FLT_OFF;
  initial begin
    CLR     = o(4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
    ARED    = o(4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    FLT_ON  = o(4'hF, 4'h0, 4'h0, 1'b0, 1'b1);
    FLT_OFF = o(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
  end

  task automatic check_val(string nm, logic [13:0] got, logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got red=%b yel=%b grn=%b clearing=%b fault=%b, expected red=%b yel=%b grn=%b clearing=%b fault=%b",
               nm, got[13:10], got[9:6], got[5:2], got[1], got[0],
               exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_invariants(string nm);
    checks++;
    if ($countones(lamp_green | lamp_yellow) > 1) begin
      fails++;
      $display("FAIL %s_one_lit: got grn=%b yel=%b, expected at most one bit set", nm, lamp_green, lamp_yellow);
    end
    checks++;
    if (fault && ((lamp_green | lamp_yellow) != 4'h0)) begin
      fails++;
      $display("FAIL %s_fault_dark: got grn=%b yel=%b, expected both 0 in fault", nm, lamp_green, lamp_yellow);
    end
  endtask

  task automatic check_pop();
    logic [13:0] e;
    string       nm;
    if (sb_exp.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard_empty: got output %b with no expectation queued, expected one queued", dut_out);
    end else begin
      e  = sb_exp.pop_front();
      nm = sb_name.pop_front();
      check_val(nm, dut_out, e);
      check_invariants(nm);
    end
  endtask

  // Entered and left at a falling edge.
  task automatic apply(string nm, logic [3:0] code, logic clr, logic [13:0] e);
    light_signal = code;
    flash_clr    = clr;
    sb_exp.push_back(e);
    sb_name.push_back(nm);
    @(posedge clk);
    #1;
    check_pop();
    @(negedge clk);
  endtask

  task automatic add(string nm, logic [3:0] code, logic clr, int unsigned n, logic [13:0] e);
    tbl.push_back('{name: nm, code: code, clr: clr, n: n, exp: e});
  endtask

  task automatic run_table();
    for (int unsigned i = 0; i < tbl.size(); i++)
      for (int unsigned k = 0; k < tbl[i].n; k++)
        apply(tbl[i].name, tbl[i].code, tbl[i].clr, tbl[i].exp);
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and startup clearance
    repeat (3) @(negedge clk);
    check_val("reset_state", dut_out, CLR);
    rst_n = 1'b1;
    check_val("post_release", dut_out, CLR);

    add("startup_clear",   4'd1,  1'b0, 3,  CLR);
    add("startup_green",   4'd1,  1'b0, 1,  grn(4'b0001));
    add("green_hold",      4'd1,  1'b0, 2,  grn(4'b0001));
    add("ns1_yellow_req",  4'd2,  1'b0, 1,  yel(4'b0001));
    add("ns1_yellow_dwell",4'd0,  1'b0, 2,  yel(4'b0001));
    add("ns1_clearance",   4'd0,  1'b0, 4,  CLR);
    add("all_red",         4'd0,  1'b0, 1,  ARED);
    add("stray_yellow",    4'd2,  1'b0, 2,  ARED);
    add("ns1_green",       4'd1,  1'b0, 1,  grn(4'b0001));
    add("forced_yellow",   4'd5,  1'b0, 3,  yel(4'b0001));
    add("forced_clear",    4'd5,  1'b0, 4,  CLR);
    add("ew1_green",       4'd5,  1'b0, 1,  grn(4'b0100));
    add("ew1_yellow",      4'd3,  1'b0, 3,  yel(4'b0100));
    add("ew1_clear",       4'd3,  1'b0, 4,  CLR);
    add("ns2_green",       4'd3,  1'b0, 1,  grn(4'b0010));
    add("ns2_yellow_hold", 4'd4,  1'b0, 10, yel(4'b0010));
    add("ns2_yellow_exit", 4'd3,  1'b0, 1,  CLR);
    add("ns2_clear",       4'd7,  1'b0, 3,  CLR);
    add("ew2_green",       4'd7,  1'b0, 1,  grn(4'b1000));
    add("ew2_yellow",      4'd8,  1'b0, 1,  yel(4'b1000));
    add("ew2_no_regreen",  4'd7,  1'b0, 2,  yel(4'b1000));
    add("ew2_clear",       4'd7,  1'b0, 4,  CLR);
    add("ew2_green_again", 4'd7,  1'b0, 1,  grn(4'b1000));
    add("fault_flash_on",  4'd12, 1'b0, 8,  FLT_ON);
    add("fault_flash_off", 4'd12, 1'b0, 8,  FLT_OFF);
    add("clr_nonzero_on",  4'd1,  1'b1, 8,  FLT_ON);
    add("clr_nonzero_off", 4'd1,  1'b1, 3,  FLT_OFF);
    add("fault_exit",      4'd0,  1'b1, 1,  CLR);
    add("exit_clear",      4'd1,  1'b0, 3,  CLR);
    add("exit_green",      4'd1,  1'b0, 1,  grn(4'b0001));
    add("ill_yellow",      4'd2,  1'b0, 1,  yel(4'b0001));
    add("ill_yellow_dwell",4'd0,  1'b0, 2,  yel(4'b0001));
    add("illegal_at_cnt0", 4'd9,  1'b0, 1,  FLT_ON);
    add("fault_exit2",     4'd0,  1'b1, 1,  CLR);
    add("exit2_clear",     4'd1,  1'b0, 3,  CLR);
    add("exit2_green",     4'd1,  1'b0, 1,  grn(4'b0001));
    add("pre_reset_yellow",4'd2,  1'b0, 1,  yel(4'b0001));
    run_table();

    // Asynchronous reset in the middle of a yellow dwell
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_mid_yellow", dut_out, CLR);
    @(negedge clk);
    rst_n = 1'b1;
    check_val("release_mid_yellow", dut_out, CLR);
    add("rst_clear",       4'd1,  1'b0, 3,  CLR);
    add("rst_green",       4'd1,  1'b0, 1,  grn(4'b0001));
    add("fault_again",     4'd15, 1'b0, 1,  FLT_ON);
    run_table();

    // Asynchronous reset while in fault
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_in_fault", dut_out, CLR);
    @(negedge clk);
    rst_n = 1'b1;
    add("rst2_clear",      4'd0,  1'b0, 3,  CLR);
    add("rst2_all_red",    4'd0,  1'b0, 1,  ARED);
    add("all_red_illegal", 4'd13, 1'b0, 1,  FLT_ON);
    run_table();

    checks++;
    if (sb_exp.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_exp.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
